// File: rtl/dcm_lock_supervisor.sv
// DCM power-up supervisor: pulses the DCM reset, waits for a stable lock and only then releases sys_reset.
// Optional timeout/retry/fail handling is enabled with `define DCM_LOCK_TIMEOUT_EN.
module dcm_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       dcm_locked,
  output logic       dcm_reset,
  output logic       sys_reset,
  output logic       lock_fail,
  output logic [2:0] retry_count
);

  typedef enum logic [2:0] {DCM_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

  localparam logic [15:0] PULSE_LAST  = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  if (RST_PULSE_CYCLES < 1 || RST_PULSE_CYCLES > 255 ||
      LOCK_TIMEOUT_CYCLES < 1 || LOCK_TIMEOUT_CYCLES > 65535 ||
      STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
      MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_bad_params
    $error("dcm_lock_supervisor: parameter out of range");
  end

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        sync_q, locked_s;

`ifdef DCM_LOCK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);
  logic [2:0] retry_q, retry_nxt;
  logic       attempt_failed;
`endif

  // dcm_locked comes from the DCM's own clock domain
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) {sync_q, locked_s} <= 2'b00;
    else       {sync_q, locked_s} <= {dcm_locked, sync_q};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
`ifdef DCM_LOCK_TIMEOUT_EN
    attempt_failed = 1'b0;
    retry_nxt      = retry_q;
`endif
    unique case (state)
      DCM_RST: if (cnt == PULSE_LAST) begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
      WAIT_LOCK: begin
        // lock wins over a timeout landing on the same cycle
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
`ifdef DCM_LOCK_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) attempt_failed = 1'b1;
`else
        else cnt_nxt = '0;
`endif
      end
      STABLE: begin
        if (!locked_s) begin
`ifdef DCM_LOCK_TIMEOUT_EN
          attempt_failed = 1'b1;
`else
          state_nxt = DCM_RST;
          cnt_nxt   = '0;
`endif
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) state_nxt = DCM_RST;
      end
      default: cnt_nxt = '0;
    endcase
`ifdef DCM_LOCK_TIMEOUT_EN
    if (attempt_failed) begin
      cnt_nxt = '0;
      if (retry_q != RETRY_MAX) retry_nxt = retry_q + 3'd1;
      state_nxt = (retry_q + 3'd1 == RETRY_MAX) ? FAIL : DCM_RST;
    end
`endif
  end

  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state     <= DCM_RST;
      cnt       <= '0;
      dcm_reset <= 1'b1;
      sys_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dcm_reset <= (state_nxt == DCM_RST) || (state_nxt == FAIL);
      sys_reset <= (state_nxt != RUN);
    end
  end

`ifdef DCM_LOCK_TIMEOUT_EN
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      retry_q   <= '0;
      lock_fail <= 1'b0;
    end else begin
      retry_q   <= retry_nxt;
      lock_fail <= (state_nxt == FAIL);
    end
  end
  assign retry_count = retry_q;
`else
  assign lock_fail   = 1'b0;
  assign retry_count = 3'd0;
`endif

endmodule

// File: doc/dcm_lock_supervisor.md
DCM_LOCK_SUPERVISOR -- requirements
Module: dcm_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 4: length of each dcm_reset pulse, in clock cycles (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535: cycles allowed for lock after a dcm_reset pulse ends (range 1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before sys_reset releases (range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed lock attempts tolerated before the fail state (range 1..7).
REQ-005 system_clock  input  1  free-running input clock (undivided board clock, pre-DCM).
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 dcm_locked  input  1  DCM LOCKED status, asynchronous to system_clock.
REQ-008 dcm_reset  output  1  registered; drives the DCM RST pin.
REQ-009 sys_reset  output  1  registered, active-high; reset for all downstream logic.
REQ-010 lock_fail  output  1  registered, sticky; high when retries are exhausted.
REQ-011 retry_count  output  3  registered; count of failed lock attempts since reset.

Function
REQ-012 dcm_locked SHALL pass through a 2-flop synchronizer; locked_s denotes the second flop; all decisions use locked_s.
REQ-013 FSM states SHALL be: DCM_RST, WAIT_LOCK, STABLE, RUN, FAIL.
REQ-014 DCM_RST: dcm_reset=1, sys_reset=1; exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK; cycle counter cleared on entry.
REQ-015 WAIT_LOCK: dcm_reset=0, sys_reset=1; locked_s=1 -> STABLE; counter reaches LOCK_TIMEOUT_CYCLES with locked_s=0 -> timeout (REQ-019).
REQ-016 STABLE: counts consecutive cycles with locked_s=1; at STABLE_CYCLES -> RUN; locked_s=0 -> counter cleared, retry_count+1, then DCM_RST, or FAIL if retry_count+1 equals MAX_RETRIES.
REQ-017 RUN: sys_reset=0 from the first cycle in RUN; dcm_reset=0.
REQ-018 RUN with locked_s=0: sys_reset=1 on the next clock edge, go to DCM_RST; retry_count is not incremented; lock loss after a successful RUN is not an attempt failure.
REQ-019 Timeout: retry_count+1; FAIL if the new value equals MAX_RETRIES, otherwise DCM_RST.
REQ-020 FAIL: dcm_reset=1, sys_reset=1, lock_fail=1; state is terminal and exits only via reset.
REQ-021 retry_count SHALL saturate at MAX_RETRIES; it never wraps.
REQ-022 Counters SHALL be 16 bits and compare with ==; no wrap-around occurs within legal parameter ranges.
REQ-023 Simultaneous timeout and locked_s rising in the same cycle: lock takes priority, go to STABLE.

Reset
REQ-024 Asserting reset SHALL asynchronously force state=DCM_RST, dcm_reset=1, sys_reset=1, lock_fail=0, retry_count=0, all counters=0, synchronizer flops=0.
REQ-025 After reset deasserts, a full RST_PULSE_CYCLES pulse SHALL occur; reset mid-operation, including in FAIL, restarts this sequence.
REQ-026 sys_reset SHALL never be low while state is not RUN.

Configuration
REQ-027 Macro DCM_LOCK_TIMEOUT_EN SHALL control the timeout and retry logic.
REQ-028 With DCM_LOCK_TIMEOUT_EN defined: behaviour is as stated in REQ-015, REQ-016, REQ-019, REQ-020 and REQ-021.
REQ-029 Without it: WAIT_LOCK waits indefinitely; lock loss in STABLE returns to DCM_RST with no count; FAIL is unreachable; lock_fail and retry_count are tied to 0; timeout counter logic is removed.

Verification
Scenario parameters (REQ-030 to REQ-034): RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2, macro defined.
REQ-030 Normal lock: release reset, raise dcm_locked at cycle 10 and hold it -> dcm_reset high cycles 1-4; sys_reset low 2 (sync) + 8 cycles after the rise, i.e. about cycle 20; lock_fail=0, retry_count=0.
REQ-031 Never lock: hold dcm_locked=0 -> two dcm_reset pulses of 4 cycles separated by 20 cycles; then FAIL with lock_fail=1, retry_count=2, dcm_reset=1 held.
REQ-032 Glitch in STABLE: lock, drop dcm_locked for 1 cycle after 5 stable cycles -> retry_count=1, new 4-cycle dcm_reset pulse, sys_reset stays 1 throughout.
REQ-033 Lock loss in RUN: drop dcm_locked in RUN -> sys_reset=1 within 3 cycles of the drop, 4-cycle dcm_reset pulse, retry_count unchanged; relock -> sys_reset=0 again after 8 stable cycles.
REQ-034 Async reset in FAIL: pulse reset mid-cycle -> outputs go to reset values immediately, not at the next clock edge; a fresh DCM_RST sequence follows.
REQ-035 Macro undefined: hold dcm_locked=0 for 200 cycles -> single dcm_reset pulse, no retries, lock_fail=0, sys_reset=1; raise dcm_locked -> RUN after 2+8 cycles.
